fp_addmul_ctrl: RTL and testbench

FP_ADDMUL_CTRL -- requirements
Module: fp_addmul_ctrl

---
 rtl/fp_addmul_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_fp_addmul_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp_addmul_ctrl.sv
// fp_addmul_ctrl: multi-cycle floating-point add / subtract / multiply unit.
// Operands use the IEEE-style layout sign|exponent|fraction. Subnormal inputs
// are flushed to zero. Rounding is round-to-nearest, ties-to-even. Any operand
// whose exponent field is all-ones (NaN or infinity) gives a canonical quiet
// NaN. The sequencing FSM is IDLE -> ALIGN -> EXEC -> NORM.. -> ROUND -> CHECK
// -> DONE. Special operands leave ALIGN early. An exact-zero sum leaves EXEC
// early.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   start               request an operation (sampled in IDLE)
//   op[1:0]             00 add, 01 sub (a-b), 10 mul, 11 treated as add
//   in_a, in_b [W-1:0]  operands, W = 1+EXP_W+MAN_W
//   out [W-1:0]         registered result, held until the next result
//   done                result valid (state DONE, held while start=1)
//   busy                operation in progress
//   overflow, underflow, invalid   status of the last operation
module fp_addmul_ctrl #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic [EXP_W+MAN_W:0] out,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int AW = MAN_W + 4;        // hidden | frac | G R S
  localparam int SW = MAN_W + 5;        // carry | hidden | frac | G R S
  localparam int XW = EXP_W + 2;        // signed working exponent
  localparam int PW = 2 * (MAN_W + 1);  // full product width

  localparam logic signed [XW-1:0] BIAS   = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [XW-1:0] EMAX   = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [XW-1:0] ONE_X  = {{(XW-1){1'b0}}, 1'b1};
  localparam logic signed [XW-1:0] ZERO_X = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_EXEC, S_NORM, S_ROUND, S_CHECK, S_DONE
  } state_t;

  state_t state_q, state_d;

  // control / architectural outputs (reset)
  logic [W-1:0] out_q, out_d;
  logic         ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  // datapath (not reset)
  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic [1:0]             op_q, op_d;
  logic                   sign_q, sign_d, sa_q, sa_d, sbx_q, sbx_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic [SW-1:0]          sig_q, sig_d;
  logic [AW-1:0]          siga_q, siga_d, sigb_q, sigb_d;

  // Right-shift an aligned significand. The shift saturates at AW-1, which
  // parks the hidden bit in the sticky position. Every bit shifted out is
  // ORed into the sticky bit.
  function automatic logic [AW-1:0] align_shift(input logic [AW-1:0] v,
                                                input logic [EXP_W-1:0] d);
    int            sh;
    logic [AW-1:0] mask;
    logic [AW-1:0] r;
    sh = int'(d);
    if (sh > AW - 1) sh = AW - 1;
    mask = ~({AW{1'b1}} << sh);
    r    = v >> sh;
    r[0] = r[0] | (|(v & mask));
    return r;
  endfunction

  // Round to nearest, ties to even. The result keeps carry|hidden|frac with
  // GRS cleared. A carry-out is left for CHECK to renormalize.
  function automatic logic [SW-1:0] round_rne(input logic [SW-1:0] s);
    logic [MAN_W+1:0] m;
    logic             up;
    m  = s[SW-1:3];
    up = s[2] & (s[1] | s[0] | s[3]);
    m  = m + {{(MAN_W+1){1'b0}}, up};
    return {m, 3'b000};
  endfunction

  // operand unpack
  logic             sa, sb, sbx, is_mul, is_sub, a_zero, b_zero, any_nan;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [PW-1:0]    prod;

  assign sa      = a_q[W-1];
  assign sb      = b_q[W-1];
  assign ea      = a_q[W-2:MAN_W];
  assign eb      = b_q[W-2:MAN_W];
  assign fa      = a_q[MAN_W-1:0];
  assign fb      = b_q[MAN_W-1:0];
  assign is_mul  = (op_q == 2'b10);
  assign is_sub  = (op_q == 2'b01);
  assign sbx     = sb ^ is_sub;
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign any_nan = (&ea) | (&eb);
  assign prod    = {{(MAN_W+1){1'b0}}, siga_q[AW-1:3]} *
                   {{(MAN_W+1){1'b0}}, sigb_q[AW-1:3]};

  logic                 cy;
  logic signed [XW-1:0] ec;
  logic [MAN_W-1:0]     frac_c;

  assign cy     = sig_q[SW-1];
  assign ec     = cy ? (exp_q + ONE_X) : exp_q;
  assign frac_c = cy ? sig_q[MAN_W+3:4] : sig_q[MAN_W+2:3];

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inv_d   = inv_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sign_d  = sign_q;
    sa_d    = sa_q;
    sbx_d   = sbx_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    siga_d  = siga_q;
    sigb_d  = sigb_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = op;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = S_ALIGN;
        end
      end

      S_ALIGN: begin
        state_d = S_EXEC;
        if (any_nan) begin
          out_d   = QNAN;
          inv_d   = 1'b1;
          state_d = S_DONE;
        end else if (is_mul && (a_zero || b_zero)) begin
          out_d   = {sa ^ sb, {(W-1){1'b0}}};
          state_d = S_DONE;
        end else if (!is_mul && a_zero && b_zero) begin
          out_d   = {sa & sbx, {(W-1){1'b0}}};
          state_d = S_DONE;
        end else if (!is_mul && a_zero) begin
          out_d   = {sbx, b_q[W-2:0]};
          state_d = S_DONE;
        end else if (!is_mul && b_zero) begin
          out_d   = a_q;
          state_d = S_DONE;
        end else if (is_mul) begin
          exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
          sign_d = sa ^ sb;
          siga_d = {1'b1, fa, 3'b000};
          sigb_d = {1'b1, fb, 3'b000};
        end else begin
          sa_d  = sa;
          sbx_d = sbx;
          if (ea >= eb) begin
            exp_d  = $signed({2'b00, ea});
            siga_d = {1'b1, fa, 3'b000};
            sigb_d = align_shift({1'b1, fb, 3'b000}, ea - eb);
          end else begin
            exp_d  = $signed({2'b00, eb});
            siga_d = align_shift({1'b1, fa, 3'b000}, eb - ea);
            sigb_d = {1'b1, fb, 3'b000};
          end
        end
      end

      S_EXEC: begin
        state_d = S_NORM;
        if (is_mul) begin
          sig_d = {prod[PW-1:MAN_W], prod[MAN_W-1], prod[MAN_W-2],
                   |prod[MAN_W-3:0]};
        end else if (sa_q == sbx_q) begin
          sig_d  = {1'b0, siga_q} + {1'b0, sigb_q};
          sign_d = sa_q;
        end else if (siga_q == sigb_q) begin
          // exact cancellation is always +0
          out_d   = '0;
          state_d = S_DONE;
        end else if (siga_q > sigb_q) begin
          sig_d  = {1'b0, siga_q - sigb_q};
          sign_d = sa_q;
        end else begin
          sig_d  = {1'b0, sigb_q - siga_q};
          sign_d = sbx_q;
        end
      end

      S_NORM: begin
        // One shift per cycle; exit once the shifted value is normalized.
        if (sig_q[SW-1]) begin
          sig_d = {1'b0, sig_q[SW-1:2], sig_q[1] | sig_q[0]};
          exp_d = exp_q + ONE_X;
        end else if (!sig_q[SW-2]) begin
          sig_d = sig_q << 1;
          exp_d = exp_q - ONE_X;
        end
        if (!sig_d[SW-1] && sig_d[SW-2]) state_d = S_ROUND;
      end

      S_ROUND: begin
        sig_d   = round_rne(sig_q);
        state_d = S_CHECK;
      end

      S_CHECK: begin
        state_d = S_DONE;
        if (ec >= EMAX) begin
          out_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (ec <= ZERO_X) begin
          out_d = {sign_q, {(W-1){1'b0}}};
          unf_d = 1'b1;
        end else begin
          out_d = {sign_q, ec[EXP_W-1:0], frac_c};
        end
      end

      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // state / output register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inv_q   <= inv_d;
    end
  end

  // datapath register boundary
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    op_q   <= op_d;
    sign_q <= sign_d;
    sa_q   <= sa_d;
    sbx_q  <= sbx_d;
    exp_q  <= exp_d;
    sig_q  <= sig_d;
    siga_q <= siga_d;
    sigb_q <= sigb_d;
  end

  assign out       = out_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_fp_addmul_ctrl.sv
module tb_fp_addmul_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in_a, in_b, dout;
  logic        done, busy, ovf, unf, inv;

  logic        start16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, dout16;
  logic        done16, busy16, ovf16, unf16, inv16;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  fp_addmul_ctrl #(.EXP_W(8), .MAN_W(23)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .in_a(in_a), .in_b(in_b), .out(dout), .done(done), .busy(busy),
    .overflow(ovf), .underflow(unf), .invalid(inv)
  );

  fp_addmul_ctrl #(.EXP_W(5), .MAN_W(10)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op(op16),
    .in_a(a16), .in_b(b16), .out(dout16), .done(done16), .busy(busy16),
    .overflow(ovf16), .underflow(unf16), .invalid(inv16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch an operation with start held high. The capture edge is edge 1.
  // lat is the edge on which done is first seen. With perturb set, inputs
  // are scrambled and start dropped for one cycle while busy.
  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] o, input bit perturb, output int l);
    @(negedge clk);
    in_a = a; in_b = b; op = o; start = 1'b1;
    @(posedge clk); #1; l = 1;
    if (perturb) begin
      @(negedge clk);
      in_a = 32'hDEADBEEF; in_b = 32'h0; op = 2'b00; start = 1'b0;
      @(posedge clk); #1; l++;
      @(negedge clk);
      start = 1'b1;
    end
    while (!done && l < 200) begin
      @(posedge clk); #1; l++;
    end
  endtask

  task automatic release_start(input string tag);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_low"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; in_a = '0; in_b = '0;
    start16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",   dout, 32'h0);
    chk("rst_ctl",   {29'b0, done, busy, 1'b0}, 32'h0);
    chk("rst_flags", {29'b0, ovf, unf, inv}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // 1.0 + 1.0
    run32(32'h3F800000, 32'h3F800000, 2'b00, 1'b0, lat);
    chk("add_done",  {31'b0, done}, 32'd1);
    chk("add_out",   dout, 32'h40000000);
    chk("add_lat",   lat, 32'd6);
    chk("add_flags", {29'b0, ovf, unf, inv}, 32'h0);
    release_start("add");
    chk("add_hold_out", dout, 32'h40000000);

    // 1.5 * 2.0 with inputs scrambled while busy
    run32(32'h3FC00000, 32'h40000000, 2'b10, 1'b1, lat);
    chk("mul_out", dout, 32'h40400000);
    chk("mul_lat", lat, 32'd6);
    release_start("mul");

    // 1.0 - 1.0: early-zero path
    run32(32'h3F800000, 32'h3F800000, 2'b01, 1'b0, lat);
    chk("subz_out",   dout, 32'h00000000);
    chk("subz_lat",   lat, 32'd3);
    chk("subz_flags", {29'b0, ovf, unf, inv}, 32'h0);
    release_start("subz");

    // overflow
    run32(32'h7F7FFFFF, 32'h40000000, 2'b10, 1'b0, lat);
    chk("ovf_out",   dout, 32'h7F800000);
    chk("ovf_flags", {29'b0, ovf, unf, inv}, 32'h4);
    release_start("ovf");

    // underflow
    run32(32'h00800000, 32'h00800000, 2'b10, 1'b0, lat);
    chk("unf_out",   dout, 32'h00000000);
    chk("unf_flags", {29'b0, ovf, unf, inv}, 32'h2);
    release_start("unf");

    // NaN operand
    run32(32'h7FC00000, 32'h3F800000, 2'b00, 1'b0, lat);
    chk("nan_out",   dout, 32'h7FC00000);
    chk("nan_flags", {29'b0, ovf, unf, inv}, 32'h1);
    chk("nan_lat",   lat, 32'd2);
    release_start("nan");

    // mul by zero gives signed zero
    run32(32'hBF800000, 32'h00000000, 2'b10, 1'b0, lat);
    chk("mulz_out", dout, 32'h80000000);
    chk("mulz_lat", lat, 32'd2);
    release_start("mulz");

    // ties to even: exact half ulp, lsb 0 stays, lsb 1 rounds up
    run32(32'h3F800000, 32'h33800000, 2'b00, 1'b0, lat);
    chk("tie_even_out", dout, 32'h3F800000);
    release_start("tie_even");
    run32(32'h3F800001, 32'h33800000, 2'b00, 1'b0, lat);
    chk("tie_odd_out", dout, 32'h3F800002);

    // start held after done: stays in DONE, no recapture
    @(negedge clk);
    in_a = 32'h40000000; in_b = 32'h40000000; op = 2'b10;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_done", {30'b0, done, busy}, 32'h2);
    chk("hold_out",  dout, 32'h3F800002);
    release_start("hold");

    // reset in the middle of a long NORM sequence
    @(negedge clk);
    in_a = 32'h3F800001; in_b = 32'h3F800000; op = 2'b01; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #2;
    chk("abort_busy",   {31'b0, busy}, 32'd1);
    chk("abort_keep",   dout, 32'h3F800002);
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("abort_out",   dout, 32'h0);
    chk("abort_ctl",   {30'b0, done, busy}, 32'h0);
    chk("abort_flags", {29'b0, ovf, unf, inv}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // same subtraction run to completion
    run32(32'h3F800001, 32'h3F800000, 2'b01, 1'b0, lat);
    chk("sub_ulp_done",  {31'b0, done}, 32'd1);
    chk("sub_ulp_out",   dout, 32'h34000000);
    chk("sub_ulp_flags", {29'b0, ovf, unf, inv}, 32'h0);
    release_start("sub_ulp");

    // half-precision instance
    @(negedge clk);
    a16 = 16'h3C00; b16 = 16'h3C00; op16 = 2'b00; start16 = 1'b1;
    @(posedge clk); #1; lat = 1;
    while (!done16 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("h_add_out",   {16'b0, dout16}, 32'h4000);
    chk("h_add_lat",   lat, 32'd6);
    chk("h_add_flags", {29'b0, ovf16, unf16, inv16}, 32'h0);
    start16 = 1'b0;
    @(posedge clk); #1;
    chk("h_done_low", {30'b0, done16, busy16}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
